ctrl_mc: RTL and testbench
==========================

Name: ctrl_mc

Overview:
- Parametrised multi-cycle control unit for the SISC datapath; successor to the fixed 4-bit part-2 controller.
- Adds memory instructions (LOD, STR, SWP) with a wait-state handshake to memory, correct conditional-branch resolution and a latched HALT state in place of a simulation stop.
- Sits between the IR/status register and the rf, alu, mux, PC, IR and data-memory control pins.

Parameters:
OP_W, 4, opcode field width (instr[31:28] at default).
MM_W, 4, mode/condition field width; must equal status register width.
WAIT_MAX, 15, max cycles spent waiting on mem_ready in one state before mem_err; range 1..255.
AM_IMM, 8, mm value selecting immediate ALU operand.

Ports:
clk  in  1  system clock, posedge.
rst_f  in  1  synchronous reset, active-high.
opcode  in  OP_W  current IR opcode.
mm  in  MM_W  current IR mode/condition field.
stat  in  MM_W  status register output.
mem_ready  in  1  memory completed this cycle's request.
rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst  out  1 each  datapath controls, same meaning as part-2 controller.
alu_op  out  2  bit1 = do not save status, bit0 = immediate operand.
mm_sel  out  1  0 = memory address from PC, 1 = from ALU result.
mem_req  out  1  memory access request.
dm_we  out  1  data-memory write strobe.
halted  out  1  high while in HALT.
mem_err  out  1  sticky; set on wait timeout.
state  out  3  encoded present state (debug).

Behaviour:
- States/encoding: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Reset: rst_f high at posedge clk -> state=START1 next cycle, mem_err=0, wait counter=0. Reset overrides any state including HALT and mid-wait MEM/FETCH.
- Outputs are Moore/Mealy combinational on (state, opcode, mm, stat, mem_ready). Defaults: all 0 except alu_op=2'b10.
- START0/START1: pc_rst=1. START1 -> FETCH.
- FETCH: mem_req=1, mm_sel=0. While mem_ready=0, stay. On mem_ready=1: ir_load=1, pc_sel=0, pc_write=1 (PC+1), go to DECODE.
- DECODE: br_sel=1 for BRA/BNE, 0 otherwise. rb_sel=1 for STR. Opcode HLT -> HALT; else -> EXECUTE.
- EXECUTE:
  - ALU_OP: alu_op=2'b01 if mm==AM_IMM else 2'b00.
  - LOD/STR/SWP: alu_op=2'b11 (address add, status not saved).
  - Branch taken = (mm==0) | ((BRA|BRR) & |(mm&stat)) | ((BNE|BNR) & ~|(mm&stat)). If taken: pc_sel=1, pc_write=1, br_sel per DECODE rule.
  - Next: MEM for LOD/STR/SWP; WRITEBACK for ALU_OP; FETCH for NOOP and branches.
- MEM: mem_req=1, mm_sel=1, alu_op=2'b11. STR and SWP also dm_we=1. Hold until mem_ready=1, then -> WRITEBACK (LOD/SWP) or FETCH (STR).
- WRITEBACK: rf_we=1. ALU_OP: wb_sel=0, alu_op=2'b10 (status saved exactly once). LOD/SWP: wb_sel=1. -> FETCH.
- HALT: all outputs default; halted=1. No exit except reset.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEM with mem_req=1 and mem_ready=0; clears on state change.
  - Reaching WAIT_MAX sets mem_err and forces HALT next cycle.
- Unknown opcodes behave as NOOP.
- rst_f coincident with mem_ready=1: reset wins; no ir_load or pc_write effect is required.

Test Plan:
1. Reset, then mem_ready tied 1, opcode=8, mm=0 -> states 1,2,3,4,6,2. pc_write=1 only in FETCH. rf_we=1 only in WRITEBACK. alu_op=00 in EXECUTE, 10 in WRITEBACK.
2. opcode=8, mm=8 -> EXECUTE alu_op=01.
3. Branches with stat=4'b0100:
   - opcode=4, mm=4'b0100 -> EXECUTE pc_sel=1, pc_write=1, br_sel=1.
   - opcode=6, same mm -> pc_write=0.
   - opcode=5, mm=0 -> taken, br_sel=0.
4. opcode=2 (STR), mem_ready low for 3 cycles in MEM:
   - mem_req=1, dm_we=1 and mm_sel=1 held for 4 cycles.
   - Then FETCH, with rf_we never asserted.
5. opcode=1 (LOD), mem_ready held 0 with WAIT_MAX=4 -> mem_err=1 after 4 wait cycles, then state=7, halted=1; rst_f=1 for 1 cycle -> state=1, mem_err=0.
6. opcode=15 in DECODE -> HALT, halted=1 persists 20 cycles with all datapath strobes 0; rst_f asserted mid-MEM wait -> START1 next cycle.

Source files
------------

// File: rtl/ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mc_if
// Purpose  : Bundle between the SISC multi-cycle controller and its datapath.
//            The controller side (master) reads the IR fields, status and the
//            memory handshake, and drives every datapath control strobe.
//            The datapath side (slave) sees the same signals in reverse.
// Signals  : opcode, mm, stat, mem_ready           datapath -> controller
//            rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
//            alu_op[1:0], mm_sel, mem_req, dm_we,
//            halted, mem_err, state[2:0]           controller -> datapath
// Revision : 1.0  initial release
// ============================================================================
interface ctrl_mc_if #(
  parameter int OP_W = 4,
  parameter int MM_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [MM_W-1:0] mm;
  logic [MM_W-1:0] stat;
  logic            mem_ready;

  logic            rf_we;
  logic            wb_sel;
  logic            br_sel;
  logic            rb_sel;
  logic            ir_load;
  logic            pc_sel;
  logic            pc_write;
  logic            pc_rst;
  logic [1:0]      alu_op;
  logic            mm_sel;
  logic            mem_req;
  logic            dm_we;
  logic            halted;
  logic            mem_err;
  logic [2:0]      state;

  modport master (
    input  opcode, mm, stat, mem_ready,
    output rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
           alu_op, mm_sel, mem_req, dm_we, halted, mem_err, state
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  rf_we, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write, pc_rst,
           alu_op, mm_sel, mem_req, dm_we, halted, mem_err, state
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mc
// Purpose  : Multi-cycle control unit for the SISC datapath. Sequences
//            fetch / decode / execute / memory / writeback, resolves
//            conditional branches against the status register, waits on the
//            memory handshake and latches HALT until reset. A bounded wait
//            counter flags a stuck memory (sticky mem_err) and halts.
// Ports    : clk    system clock (posedge)
//            rst_f  synchronous reset, active-high
//            bus    ctrl_mc_if.master (IR fields, status, mem_ready in;
//                   datapath strobes, halted, mem_err, state out)
// Revision : 1.0  initial release
// ============================================================================
module ctrl_mc #(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int WAIT_MAX = 15,
  parameter int AM_IMM   = 8
) (
  input wire logic     clk,
  input wire logic     rst_f,
  ctrl_mc_if.master    bus
);

  localparam logic [OP_W-1:0] c_LOD    = OP_W'(1);
  localparam logic [OP_W-1:0] c_STR    = OP_W'(2);
  localparam logic [OP_W-1:0] c_SWP    = OP_W'(3);
  localparam logic [OP_W-1:0] c_BRA    = OP_W'(4);
  localparam logic [OP_W-1:0] c_BRR    = OP_W'(5);
  localparam logic [OP_W-1:0] c_BNE    = OP_W'(6);
  localparam logic [OP_W-1:0] c_BNR    = OP_W'(7);
  localparam logic [OP_W-1:0] c_ALU_OP = OP_W'(8);
  localparam logic [OP_W-1:0] c_HLT    = OP_W'(15);
  localparam logic [MM_W-1:0] c_AM_IMM = MM_W'(AM_IMM);
  localparam logic [7:0]      c_WAIT_LAST = 8'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  // opcode classes
  logic w_is_lod, w_is_str, w_is_swp, w_is_alu, w_is_hlt;
  logic w_br_pos, w_br_neg, w_br_abs, w_is_br, w_taken;
  logic w_waiting, w_timeout;

  assign w_is_lod = (bus.opcode == c_LOD);
  assign w_is_str = (bus.opcode == c_STR);
  assign w_is_swp = (bus.opcode == c_SWP);
  assign w_is_alu = (bus.opcode == c_ALU_OP);
  assign w_is_hlt = (bus.opcode == c_HLT);
  assign w_br_pos = (bus.opcode == c_BRA) || (bus.opcode == c_BRR);
  assign w_br_neg = (bus.opcode == c_BNE) || (bus.opcode == c_BNR);
  assign w_br_abs = (bus.opcode == c_BRA) || (bus.opcode == c_BNE);
  assign w_is_br  = w_br_pos || w_br_neg;

  // mm==0 is the unconditional form; otherwise mm masks the status bits.
  assign w_taken = (bus.mm == '0)
                || (w_br_pos &&  (|(bus.mm & bus.stat)))
                || (w_br_neg && !(|(bus.mm & bus.stat)));

  // Only FETCH and MEM issue requests, so only they can stall.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == c_WAIT_LAST);

  logic       w_rf_we, w_wb_sel, w_br_sel, w_rb_sel, w_ir_load;
  logic       w_pc_sel, w_pc_write, w_pc_rst, w_mm_sel, w_mem_req;
  logic       w_dm_we, w_halted;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state    <= S_START1;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_waiting)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout)
        r_mem_err <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rf_we    = 1'b0;
    w_wb_sel   = 1'b0;
    w_br_sel   = 1'b0;
    w_rb_sel   = 1'b0;
    w_ir_load  = 1'b0;
    w_pc_sel   = 1'b0;
    w_pc_write = 1'b0;
    w_pc_rst   = 1'b0;
    w_alu_op   = 2'b10;
    w_mm_sel   = 1'b0;
    w_mem_req  = 1'b0;
    w_dm_we    = 1'b0;
    w_halted   = 1'b0;

    case (r_state)
      S_START0: begin
        w_pc_rst = 1'b1;
        w_next   = S_START1;
      end
      S_START1: begin
        w_pc_rst = 1'b1;
        w_next   = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_load  = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_br_sel = w_br_abs;
        w_rb_sel = w_is_str;
        w_next   = w_is_hlt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_next = S_FETCH;
        if (w_is_alu) begin
          w_alu_op = (bus.mm == c_AM_IMM) ? 2'b01 : 2'b00;
          w_next   = S_WRITEBACK;
        end else if (w_is_lod || w_is_str || w_is_swp) begin
          // address add; status must not be disturbed by it
          w_alu_op = 2'b11;
          w_next   = S_MEM;
        end else if (w_is_br && w_taken) begin
          w_pc_sel   = 1'b1;
          w_pc_write = 1'b1;
          w_br_sel   = w_br_abs;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mm_sel  = 1'b1;
        w_alu_op  = 2'b11;
        w_dm_we   = w_is_str || w_is_swp;
        if (bus.mem_ready)
          w_next = (w_is_lod || w_is_swp) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        w_rf_we  = 1'b1;
        w_wb_sel = w_is_lod || w_is_swp;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_START1;
    endcase

    if (w_timeout)
      w_next = S_HALT;
  end

  assign bus.rf_we    = w_rf_we;
  assign bus.wb_sel   = w_wb_sel;
  assign bus.br_sel   = w_br_sel;
  assign bus.rb_sel   = w_rb_sel;
  assign bus.ir_load  = w_ir_load;
  assign bus.pc_sel   = w_pc_sel;
  assign bus.pc_write = w_pc_write;
  assign bus.pc_rst   = w_pc_rst;
  assign bus.alu_op   = w_alu_op;
  assign bus.mm_sel   = w_mm_sel;
  assign bus.mem_req  = w_mem_req;
  assign bus.dm_we    = w_dm_we;
  assign bus.halted   = w_halted;
  assign bus.mem_err  = r_mem_err;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_mc
// Purpose  : Directed self-checking bench for ctrl_mc (WAIT_MAX=4 instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_mc;

  logic clk = 1'b0;
  logic rst_f;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ctrl_mc_if #(.OP_W(4), .MM_W(4)) bus ();

  ctrl_mc #(.OP_W(4), .MM_W(4), .WAIT_MAX(4), .AM_IMM(8)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  // advance one clock; outputs are looked at 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_f = 1'b1; bus.opcode = 4'd8; bus.mm = 4'd0; bus.stat = 4'd0; bus.mem_ready = 1'b1;
    step();
    rst_f = 1'b0;
    #1;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL reset_state got=%0d exp=1", bus.state); end
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", bus.mem_err); end
    checks++; if ({bus.pc_rst, bus.alu_op, bus.pc_write} !== 4'b1100) begin errors++; $display("FAIL reset_outs got=%b exp=1100", {bus.pc_rst, bus.alu_op, bus.pc_write}); end
  endtask

  // opcode 8, mm 0: 1 -> 2 -> 3 -> 4 -> 6 -> 2
  task automatic test_alu_reg();
    step();
    checks++; if ({bus.state, bus.pc_write, bus.ir_load, bus.mem_req, bus.rf_we} !== {3'd2, 4'b1110}) begin errors++; $display("FAIL alu_fetch got=%b exp=0101110", {bus.state, bus.pc_write, bus.ir_load, bus.mem_req, bus.rf_we}); end
    step();
    checks++; if ({bus.state, bus.pc_write, bus.rf_we} !== {3'd3, 2'b00}) begin errors++; $display("FAIL alu_decode got=%b exp=01100", {bus.state, bus.pc_write, bus.rf_we}); end
    step();
    checks++; if ({bus.state, bus.alu_op, bus.pc_write, bus.rf_we} !== {3'd4, 2'b00, 2'b00}) begin errors++; $display("FAIL alu_execute got=%b exp=1000000", {bus.state, bus.alu_op, bus.pc_write, bus.rf_we}); end
    step();
    checks++; if ({bus.state, bus.alu_op, bus.rf_we, bus.wb_sel, bus.pc_write} !== {3'd6, 2'b10, 3'b100}) begin errors++; $display("FAIL alu_writeback got=%b exp=11010100", {bus.state, bus.alu_op, bus.rf_we, bus.wb_sel, bus.pc_write}); end
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL alu_back_to_fetch got=%0d exp=2", bus.state); end
  endtask

  task automatic test_alu_imm();
    bus.mm = 4'd8;
    step(); step();
    checks++; if ({bus.state, bus.alu_op} !== {3'd4, 2'b01}) begin errors++; $display("FAIL alu_imm got=%b exp=10001", {bus.state, bus.alu_op}); end
    step(); step();
  endtask

  task automatic test_branches();
    bus.stat = 4'b0100;
    // BRA, condition bit matches: taken, absolute
    bus.opcode = 4'd4; bus.mm = 4'b0100;
    step();
    checks++; if ({bus.state, bus.br_sel} !== {3'd3, 1'b1}) begin errors++; $display("FAIL bra_decode got=%b exp=0111", {bus.state, bus.br_sel}); end
    step();
    checks++; if ({bus.state, bus.pc_sel, bus.pc_write, bus.br_sel} !== {3'd4, 3'b111}) begin errors++; $display("FAIL bra_taken got=%b exp=100111", {bus.state, bus.pc_sel, bus.pc_write, bus.br_sel}); end
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL bra_to_fetch got=%0d exp=2", bus.state); end
    // BNE, bit set: not taken
    bus.opcode = 4'd6;
    step(); step();
    checks++; if ({bus.state, bus.pc_write} !== {3'd4, 1'b0}) begin errors++; $display("FAIL bne_not_taken got=%b exp=1000", {bus.state, bus.pc_write}); end
    step();
    // BRR, mm=0: unconditional, relative
    bus.opcode = 4'd5; bus.mm = 4'd0;
    step(); step();
    checks++; if ({bus.state, bus.pc_sel, bus.pc_write, bus.br_sel} !== {3'd4, 3'b110}) begin errors++; $display("FAIL brr_uncond got=%b exp=100110", {bus.state, bus.pc_sel, bus.pc_write, bus.br_sel}); end
    step();
  endtask

  task automatic test_unknown_noop();
    bus.opcode = 4'd9; bus.mm = 4'd0;
    step(); step();
    checks++; if ({bus.state, bus.pc_write, bus.alu_op} !== {3'd4, 1'b0, 2'b10}) begin errors++; $display("FAIL noop_execute got=%b exp=100010", {bus.state, bus.pc_write, bus.alu_op}); end
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL noop_to_fetch got=%0d exp=2", bus.state); end
  endtask

  task automatic test_store_wait();
    bus.opcode = 4'd2; bus.mm = 4'd0;
    step();
    checks++; if (bus.rb_sel !== 1'b1) begin errors++; $display("FAIL str_rb_sel got=%b exp=1", bus.rb_sel); end
    step();
    checks++; if (bus.alu_op !== 2'b11) begin errors++; $display("FAIL str_exec_alu got=%b exp=11", bus.alu_op); end
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus.mem_ready = 1'b1; #1; end
      checks++; if ({bus.state, bus.mem_req, bus.dm_we, bus.mm_sel, bus.rf_we} !== {3'd5, 4'b1110}) begin errors++; $display("FAIL str_mem_hold cyc=%0d got=%b exp=1011110", i, {bus.state, bus.mem_req, bus.dm_we, bus.mm_sel, bus.rf_we}); end
      step();
    end
    checks++; if ({bus.state, bus.rf_we} !== {3'd2, 1'b0}) begin errors++; $display("FAIL str_done got=%b exp=0100", {bus.state, bus.rf_we}); end
  endtask

  task automatic test_swap();
    bus.opcode = 4'd3;
    step(); step(); step();
    checks++; if ({bus.state, bus.dm_we, bus.mem_req} !== {3'd5, 2'b11}) begin errors++; $display("FAIL swp_mem got=%b exp=10111", {bus.state, bus.dm_we, bus.mem_req}); end
    step();
    checks++; if ({bus.state, bus.rf_we, bus.wb_sel} !== {3'd6, 2'b11}) begin errors++; $display("FAIL swp_writeback got=%b exp=11011", {bus.state, bus.rf_we, bus.wb_sel}); end
    step();
  endtask

  task automatic test_load_timeout();
    bus.opcode = 4'd1;
    step(); step();
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus.state, bus.mem_err} !== {3'd5, 1'b0}) begin errors++; $display("FAIL lod_waiting cyc=%0d got=%b exp=1010", i, {bus.state, bus.mem_err}); end
      step();
    end
    checks++; if ({bus.state, bus.mem_err, bus.halted} !== {3'd7, 2'b11}) begin errors++; $display("FAIL lod_timeout got=%b exp=11111", {bus.state, bus.mem_err, bus.halted}); end
    step();
    checks++; if ({bus.state, bus.mem_err} !== {3'd7, 1'b1}) begin errors++; $display("FAIL mem_err_sticky got=%b exp=1111", {bus.state, bus.mem_err}); end
    rst_f = 1'b1;
    step();
    rst_f = 1'b0;
    checks++; if ({bus.state, bus.mem_err, bus.halted} !== {3'd1, 2'b00}) begin errors++; $display("FAIL timeout_reset got=%b exp=00100", {bus.state, bus.mem_err, bus.halted}); end
  endtask

  task automatic test_halt();
    bus.mem_ready = 1'b1; bus.opcode = 4'd15;
    step(); step(); step();
    checks++; if ({bus.state, bus.halted} !== {3'd7, 1'b1}) begin errors++; $display("FAIL hlt_enter got=%b exp=1111", {bus.state, bus.halted}); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if ({bus.state, bus.halted, bus.rf_we, bus.pc_write, bus.ir_load, bus.mem_req, bus.dm_we, bus.pc_rst}
                    !== {3'd7, 1'b1, 6'b000000}) begin errors++; $display("FAIL hlt_hold cyc=%0d got=%b exp=1111000000", i, {bus.state, bus.halted, bus.rf_we, bus.pc_write, bus.ir_load, bus.mem_req, bus.dm_we, bus.pc_rst}); end
    end
  endtask

  task automatic test_reset_mid_wait();
    rst_f = 1'b1; step(); rst_f = 1'b0;
    bus.opcode = 4'd1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    step(); step();
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL mid_wait_state got=%0d exp=5", bus.state); end
    rst_f = 1'b1;
    step();
    rst_f = 1'b0;
    checks++; if ({bus.state, bus.mem_err, bus.mem_req} !== {3'd1, 2'b00}) begin errors++; $display("FAIL mid_wait_reset got=%b exp=00100", {bus.state, bus.mem_err, bus.mem_req}); end
  endtask

  initial begin
    rst_f = 1'b1;
    bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_ready = 1'b0;
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_branches();
    test_unknown_noop();
    test_store_wait();
    test_swap();
    test_load_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
